// File: rtl/sprite_compositor_pkg.sv
// rtl/sprite_compositor_pkg.sv - shared widths, raster offsets and colour expansion
package sprite_compositor_pkg;

    localparam int RGB3_W           = 3;
    localparam int SCALE_W          = 2;
    localparam int H_OFFSET_DEFAULT = 144;
    localparam int V_OFFSET_DEFAULT = 35;

    function automatic logic [23:0] expand_rgb(input logic [RGB3_W-1:0] c);
        return {{8{c[2]}}, {8{c[1]}}, {8{c[0]}}};
    endfunction

endpackage

// File: rtl/sprite_compositor_lane.sv
// rtl/sprite_compositor_lane.sv - one sprite lane: active registers, bitmap RAM, stages 1-2
module sprite_lane
    import sprite_compositor_pkg::*;
#(
    parameter int SPR_W    = 16,
    parameter int SPR_H    = 16,
    parameter int COORD_W  = 10,
    parameter int H_OFFSET = H_OFFSET_DEFAULT,
    parameter int V_OFFSET = V_OFFSET_DEFAULT,
    parameter int AW       = $clog2(SPR_W*SPR_H)
) (
    input  logic               VGA_CLK,
    input  logic               reset_n,
    input  logic               frame_start,
    input  logic [COORD_W-1:0] shadow_x,
    input  logic [COORD_W-1:0] shadow_y,
    input  logic [SCALE_W-1:0] shadow_scale,
    input  logic               shadow_vivo,
    input  logic [COORD_W-1:0] VGA_X,
    input  logic [COORD_W-1:0] VGA_Y,
    input  logic               wr_en,
    input  logic [AW-1:0]      wr_addr,
    input  logic [RGB3_W-1:0]  wr_data,
    output logic               opaque,
    output logic [RGB3_W-1:0]  color
);

    localparam int DW = COORD_W + 2;
    localparam logic [DW-1:0] H_OFF = DW'(H_OFFSET);
    localparam logic [DW-1:0] V_OFF = DW'(V_OFFSET);

    logic [COORD_W-1:0] act_x;
    logic [COORD_W-1:0] act_y;
    logic [SCALE_W-1:0] act_scale;
    logic               act_vivo;

    logic [DW-1:0]      dx;
    logic [DW-1:0]      dy;
    logic               in_x;
    logic               in_y;
    logic [AW-1:0]      addr_c;

    logic               s1_hit;
    logic [AW-1:0]      s1_addr;
    logic [RGB3_W-1:0]  pix;

    logic [RGB3_W-1:0]  bitmap [SPR_W*SPR_H];

    always_ff @(posedge VGA_CLK or negedge reset_n) begin
        if (!reset_n) begin
            act_x     <= '0;
            act_y     <= '0;
            act_scale <= '0;
            act_vivo  <= 1'b0;
        end else if (frame_start) begin
            act_x     <= shadow_x;
            act_y     <= shadow_y;
            act_scale <= shadow_scale;
            act_vivo  <= shadow_vivo;
        end
    end

    // The sign bit of the widened difference keeps wrapped coordinates out of range.
    always_comb begin
        dx     = DW'(VGA_X) - H_OFF - DW'(act_x);
        dy     = DW'(VGA_Y) - V_OFF - DW'(act_y);
        in_x   = !dx[DW-1] && (dx < (DW'(SPR_W) << act_scale));
        in_y   = !dy[DW-1] && (dy < (DW'(SPR_H) << act_scale));
        addr_c = AW'((dy >> act_scale) * SPR_W + (dx >> act_scale));
    end

    always_ff @(posedge VGA_CLK or negedge reset_n) begin
        if (!reset_n) begin
            s1_hit  <= 1'b0;
            s1_addr <= '0;
        end else begin
            s1_hit  <= act_vivo && in_x && in_y;
            s1_addr <= addr_c;
        end
    end

    always_ff @(posedge VGA_CLK) begin
        if (wr_en) begin
            bitmap[wr_addr] <= wr_data;
        end
    end

    assign pix = bitmap[s1_addr];

    always_ff @(posedge VGA_CLK or negedge reset_n) begin
        if (!reset_n) begin
            opaque <= 1'b0;
            color  <= '0;
        end else begin
            opaque <= s1_hit && (pix != '0);
            color  <= pix;
        end
    end

endmodule

// File: rtl/sprite_compositor.sv
// rtl/sprite_compositor.sv - N-lane sprite compositor with priority select and collision flag
module sprite_compositor
    import sprite_compositor_pkg::*;
#(
    parameter int N_SPRITES = 8,
    parameter int SPR_W     = 16,
    parameter int SPR_H     = 16,
    parameter int COORD_W   = 10,
    parameter int H_OFFSET  = H_OFFSET_DEFAULT,
    parameter int V_OFFSET  = V_OFFSET_DEFAULT,
    localparam int SW       = $clog2(N_SPRITES),
    localparam int AW       = $clog2(SPR_W*SPR_H)
) (
    input  logic                           VGA_CLK,
    input  logic                           reset_n,
    input  logic [COORD_W-1:0]             VGA_X,
    input  logic [COORD_W-1:0]             VGA_Y,
    input  logic                           ativo,
    input  logic                           frame_start,
    input  logic [N_SPRITES*COORD_W-1:0]   spr_x,
    input  logic [N_SPRITES*COORD_W-1:0]   spr_y,
    input  logic [N_SPRITES*SCALE_W-1:0]   spr_scale,
    input  logic [N_SPRITES-1:0]           spr_vivo,
    input  logic [23:0]                    bg_rgb,
    input  logic                           bmp_wr_en,
    input  logic [SW-1:0]                  bmp_wr_sprite,
    input  logic [AW-1:0]                  bmp_wr_addr,
    input  logic [RGB3_W-1:0]              bmp_wr_data,
    output logic [7:0]                     VGA_R,
    output logic [7:0]                     VGA_G,
    output logic [7:0]                     VGA_B,
    output logic [N_SPRITES-1:0]           hit_mask,
    output logic                           collision_frame
);

    localparam logic [SW:0] N_LIM = (SW+1)'(N_SPRITES);
    localparam logic [AW:0] A_LIM = (AW+1)'(SPR_W*SPR_H);

    logic                 wr_ok;
    logic [N_SPRITES-1:0] opq;
    logic [RGB3_W-1:0]    lane_col [N_SPRITES];
    logic                 ativo_q1;
    logic                 ativo_q2;
    logic [RGB3_W-1:0]    win_col;
    logic [23:0]          pix_rgb;
    logic                 coll_event;
    logic                 sticky;

    assign wr_ok = bmp_wr_en && ({1'b0, bmp_wr_sprite} < N_LIM) && ({1'b0, bmp_wr_addr} < A_LIM);

    for (genvar i = 0; i < N_SPRITES; i++) begin : g_lane
        sprite_lane #(
            .SPR_W    (SPR_W),
            .SPR_H    (SPR_H),
            .COORD_W  (COORD_W),
            .H_OFFSET (H_OFFSET),
            .V_OFFSET (V_OFFSET),
            .AW       (AW)
        ) u_lane (
            .VGA_CLK      (VGA_CLK),
            .reset_n      (reset_n),
            .frame_start  (frame_start),
            .shadow_x     (spr_x[i*COORD_W +: COORD_W]),
            .shadow_y     (spr_y[i*COORD_W +: COORD_W]),
            .shadow_scale (spr_scale[i*SCALE_W +: SCALE_W]),
            .shadow_vivo  (spr_vivo[i]),
            .VGA_X        (VGA_X),
            .VGA_Y        (VGA_Y),
            .wr_en        (wr_ok && (bmp_wr_sprite == SW'(i))),
            .wr_addr      (bmp_wr_addr),
            .wr_data      (bmp_wr_data),
            .opaque       (opq[i]),
            .color        (lane_col[i])
        );
    end

    always_ff @(posedge VGA_CLK or negedge reset_n) begin
        if (!reset_n) begin
            ativo_q1 <= 1'b0;
            ativo_q2 <= 1'b0;
        end else begin
            ativo_q1 <= ativo;
            ativo_q2 <= ativo_q1;
        end
    end

    // Walk from the lowest priority upward so lane 0 overwrites everything else.
    always_comb begin
        win_col = '0;
        for (int i = N_SPRITES-1; i >= 0; i--) begin
            if (opq[i]) begin
                win_col = lane_col[i];
            end
        end
        if (!ativo_q2) begin
            pix_rgb = '0;
        end else if (opq == '0) begin
            pix_rgb = bg_rgb;
        end else begin
            pix_rgb = expand_rgb(win_col);
        end
        coll_event = ativo_q2 && ((opq & (opq - N_SPRITES'(1))) != '0);
    end

    always_ff @(posedge VGA_CLK or negedge reset_n) begin
        if (!reset_n) begin
            VGA_R           <= '0;
            VGA_G           <= '0;
            VGA_B           <= '0;
            hit_mask        <= '0;
            sticky          <= 1'b0;
            collision_frame <= 1'b0;
        end else begin
            {VGA_R, VGA_G, VGA_B} <= pix_rgb;
            hit_mask              <= opq;
            if (frame_start) begin
                collision_frame <= sticky || coll_event;
                sticky          <= 1'b0;
            end else if (coll_event) begin
                sticky <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sprite_compositor.sv
// tb/tb_sprite_compositor.sv - randomized bench for sprite_compositor against a pixel-level model
module tb_sprite_compositor;

    localparam int N  = 8;
    localparam int CW = 10;

    logic          VGA_CLK = 1'b0;
    logic          reset_n = 1'b0;
    logic [CW-1:0] VGA_X = '0;
    logic [CW-1:0] VGA_Y = '0;
    logic          ativo = 1'b0;
    logic          frame_start = 1'b0;
    logic [N*CW-1:0] spr_x = '0;
    logic [N*CW-1:0] spr_y = '0;
    logic [N*2-1:0]  spr_scale = '0;
    logic [N-1:0]    spr_vivo = '0;
    logic [23:0]     bg_rgb = 24'h123456;
    logic            bmp_wr_en = 1'b0;
    logic [2:0]      bmp_wr_sprite = '0;
    logic [7:0]      bmp_wr_addr = '0;
    logic [2:0]      bmp_wr_data = '0;
    logic [7:0]      VGA_R, VGA_G, VGA_B;
    logic [N-1:0]    hit_mask;
    logic            collision_frame;

    sprite_compositor dut (
        .VGA_CLK         (VGA_CLK),
        .reset_n         (reset_n),
        .VGA_X           (VGA_X),
        .VGA_Y           (VGA_Y),
        .ativo           (ativo),
        .frame_start     (frame_start),
        .spr_x           (spr_x),
        .spr_y           (spr_y),
        .spr_scale       (spr_scale),
        .spr_vivo        (spr_vivo),
        .bg_rgb          (bg_rgb),
        .bmp_wr_en       (bmp_wr_en),
        .bmp_wr_sprite   (bmp_wr_sprite),
        .bmp_wr_addr     (bmp_wr_addr),
        .bmp_wr_data     (bmp_wr_data),
        .VGA_R           (VGA_R),
        .VGA_G           (VGA_G),
        .VGA_B           (VGA_B),
        .hit_mask        (hit_mask),
        .collision_frame (collision_frame)
    );

    always #5 VGA_CLK = ~VGA_CLK;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic check(input string nm, input logic [23:0] got, input logic [23:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, want, $time);
        end
    endtask

    // Reference model: a pixel's fate is decided when it is sampled, then delayed to the output.
    typedef struct packed {
        bit       act;
        bit [N-1:0] hit;
        bit [2:0] col;
    } pix_t;

    int   mem [N][256];
    int   ax [N];
    int   ay [N];
    int   asc [N];
    bit   av [N];
    pix_t d1, d2, cur;
    bit   ev, sticky;
    logic [23:0] exp_rgb  = '0;
    logic [N-1:0] exp_hit = '0;
    logic        exp_coll = 1'b0;

    function automatic pix_t eval_pix();
        pix_t p;
        int dx, dy, sc, c;
        p = '0;
        p.act = ativo;
        for (int i = N-1; i >= 0; i--) begin
            dx = int'(VGA_X) - 144 - ax[i];
            dy = int'(VGA_Y) - 35 - ay[i];
            sc = 1 << asc[i];
            if (av[i] && dx >= 0 && dx < 16*sc && dy >= 0 && dy < 16*sc) begin
                c = mem[i][(dy/sc)*16 + dx/sc];
                if (c != 0) begin
                    p.hit[i] = 1'b1;
                    p.col    = c[2:0];
                end
            end
        end
        return p;
    endfunction

    always @(posedge VGA_CLK or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N; i++) begin
                ax[i] = 0; ay[i] = 0; asc[i] = 0; av[i] = 1'b0;
            end
            d1 = '0; d2 = '0; sticky = 1'b0;
            exp_rgb = '0; exp_hit = '0; exp_coll = 1'b0;
        end else begin
            if (bmp_wr_en) mem[bmp_wr_sprite][bmp_wr_addr] = int'(bmp_wr_data);
            cur = eval_pix();
            if (!d2.act)          exp_rgb = '0;
            else if (d2.hit == 0) exp_rgb = bg_rgb;
            else                  exp_rgb = {{8{d2.col[2]}}, {8{d2.col[1]}}, {8{d2.col[0]}}};
            exp_hit = d2.hit;
            ev = d2.act && ($countones(d2.hit) >= 2);
            if (frame_start) begin
                exp_coll = sticky | ev;
                sticky   = 1'b0;
            end else if (ev) begin
                sticky = 1'b1;
            end
            d2 = d1;
            d1 = cur;
            if (frame_start) begin
                for (int i = 0; i < N; i++) begin
                    ax[i]  = int'(spr_x[i*CW +: CW]);
                    ay[i]  = int'(spr_y[i*CW +: CW]);
                    asc[i] = int'(spr_scale[i*2 +: 2]);
                    av[i]  = spr_vivo[i];
                end
            end
        end
    end

    always @(negedge VGA_CLK) begin
        if (chk_en) begin
            check("cyc_rgb", {VGA_R, VGA_G, VGA_B}, exp_rgb);
            check("cyc_hit", 24'(hit_mask), 24'(exp_hit));
            check("cyc_coll", 24'(collision_frame), 24'(exp_coll));
        end
    end

    task automatic tick();
        @(posedge VGA_CLK);
        #1;
    endtask

    task automatic pulse();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic set_lane(input int i, input int x, input int y, input int s, input bit v);
        spr_x[i*CW +: CW] = CW'(x);
        spr_y[i*CW +: CW] = CW'(y);
        spr_scale[i*2 +: 2] = 2'(s);
        spr_vivo[i] = v;
    endtask

    task automatic wr(input int sp, input int a, input int d);
        bmp_wr_en = 1'b1;
        bmp_wr_sprite = 3'(sp);
        bmp_wr_addr = 8'(a);
        bmp_wr_data = 3'(d);
        tick();
        bmp_wr_en = 1'b0;
    endtask

    task automatic show(input int vx, input int vy, input logic [23:0] want_rgb,
                        input logic [N-1:0] want_hit, input string nm);
        VGA_X = CW'(vx + 144);
        VGA_Y = CW'(vy + 35);
        ativo = 1'b1;
        repeat (3) tick();
        check({nm, "_rgb"}, {VGA_R, VGA_G, VGA_B}, want_rgb);
        check({nm, "_hit"}, 24'(hit_mask), 24'(want_hit));
    endtask

    int j, vx, vy;

    initial begin
        repeat (3) tick();
        check("reset_rgb", {VGA_R, VGA_G, VGA_B}, 24'h0);
        check("reset_coll", 24'(collision_frame), 24'h0);
        reset_n = 1'b1;
        chk_en  = 1'b1;

        ativo = 1'b1;
        for (int k = 0; k < 20; k++) begin
            VGA_X = CW'($urandom);
            VGA_Y = CW'($urandom);
            tick();
        end
        check("bg_only_rgb", {VGA_R, VGA_G, VGA_B}, 24'h123456);
        check("bg_only_hit", 24'(hit_mask), 24'h0);

        for (int s = 0; s < N; s++)
            for (int a = 0; a < 256; a++)
                wr(s, a, 0);

        wr(0, 0, 3'b100);
        set_lane(0, 10, 20, 0, 1'b1);
        pulse();
        show(10, 20, 24'hFF0000, 8'h01, "lane0_red");
        show(11, 20, 24'h123456, 8'h00, "lane0_next_bg");

        wr(0, 1, 3'b010);
        set_lane(0, 10, 20, 2, 1'b1);
        pulse();
        show(13, 23, 24'hFF0000, 8'h01, "s2_corner");
        show(14, 20, 24'h00FF00, 8'h01, "s2_px1");
        show(9, 20, 24'h123456, 8'h00, "s2_left");
        show(10, 24, 24'h123456, 8'h00, "s2_row1");

        wr(3, 0, 3'b001);
        set_lane(0, 10, 20, 0, 1'b1);
        set_lane(3, 10, 20, 0, 1'b1);
        pulse();
        show(10, 20, 24'hFF0000, 8'h09, "overlap");
        VGA_X = '0;
        VGA_Y = '0;
        repeat (4) tick();
        pulse();
        check("coll_set", 24'(collision_frame), 24'h1);
        repeat (4) tick();
        pulse();
        check("coll_clear", 24'(collision_frame), 24'h0);

        set_lane(0, 100, 20, 0, 1'b1);
        show(10, 20, 24'hFF0000, 8'h09, "nomove_old");
        show(100, 20, 24'h123456, 8'h00, "nomove_new");
        pulse();
        show(100, 20, 24'hFF0000, 8'h01, "moved");

        reset_n = 1'b0;
        #1;
        check("rst_blank_rgb", {VGA_R, VGA_G, VGA_B}, 24'h0);
        check("rst_blank_hit", 24'(hit_mask), 24'h0);
        repeat (2) tick();
        reset_n = 1'b1;
        show(100, 20, 24'h123456, 8'h00, "post_rst_bg");
        pulse();
        show(100, 20, 24'hFF0000, 8'h01, "post_rst_redraw");

        for (int s = 0; s < N; s++)
            for (int a = 0; a < 256; a++)
                wr(s, a, ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 7)));

        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(0, 7) == 0) begin
                j = $urandom_range(0, N-1);
                set_lane(j,
                         ($urandom_range(0, 9) == 0) ? int'($urandom_range(560, 639)) : int'($urandom_range(0, 120)),
                         int'($urandom_range(0, 100)),
                         int'($urandom_range(0, 3)),
                         ($urandom_range(0, 3) != 0));
            end
            if ($urandom_range(0, 19) == 0) begin
                VGA_X = CW'($urandom);
                VGA_Y = CW'($urandom);
            end else begin
                j  = $urandom_range(0, N-1);
                vx = int'(spr_x[j*CW +: CW]) + int'($urandom_range(0, 150)) - 10;
                vy = int'(spr_y[j*CW +: CW]) + int'($urandom_range(0, 150)) - 10;
                VGA_X = CW'(vx + 144);
                VGA_Y = CW'(vy + 35);
            end
            ativo         = ($urandom_range(0, 7) != 0);
            frame_start   = ($urandom_range(0, 39) == 0);
            bmp_wr_en     = $urandom_range(0, 1) == 1;
            bmp_wr_sprite = 3'($urandom);
            bmp_wr_addr   = 8'($urandom);
            bmp_wr_data   = 3'($urandom);
            if ($urandom_range(0, 99) == 0) bg_rgb = 24'($urandom);
            tick();
        end
        frame_start = 1'b0;
        bmp_wr_en   = 1'b0;
        ativo       = 1'b0;
        repeat (4) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
